// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// default reset PC / exception NOP, and the alignment helper.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_VALID = 3'd2,
    ST_EXC   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  // A fetch at a misaligned pc never reaches imem; it is reported instead.
  function automatic state_e fetch_entry_state(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) ? ST_EXC : ST_REQ;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_adder.sv
// Sequential-PC incrementer: pc + 4, wrapping modulo 2^32.
module pc_adder (
  input  logic [31:0] pc_i,
  output logic [31:0] pc4_o
);

  assign pc4_o = pc_i + 32'd4;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents fetched words to IF/ID and applies redirects from later stages.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_misaligned,
  output state_e      dbg_state
);

  // Handshake: imem_req stays high with imem_addr stable until a cycle with
  // imem_ack=1 (ack may arrive in the same cycle req rises); if_valid is held
  // while stall_in=1 and the entry is consumed on the first cycle stall_in=0.

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] pc_plus4;

  pc_adder u_pc_adder (
    .pc_i  (pc_q),
    .pc4_o (pc_plus4)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    mis_d        = mis_q;
    inst_d       = inst_q;
    ipc_d        = ipc_q;
    ipc4_d       = ipc4_q;

    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: state_d = fetch_entry_state(pc_d);
      ST_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            state_d = fetch_entry_state(redirect_pc);
          end else begin
            // The request is already on the bus; finish it at the old address.
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          valid_d = 1'b1;
          inst_d  = imem_rdata;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          pc_d    = pc_plus4;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          state_d = fetch_entry_state(pc_d);
        end else if (!stall_in) begin
          valid_d = 1'b0;
          state_d = fetch_entry_state(pc_q);
        end
      end
      ST_EXC: begin
        if (redirect) begin
          state_d = fetch_entry_state(pc_d);
        end else begin
          valid_d = 1'b1;
          mis_d   = 1'b1;
          inst_d  = NOP_INST;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) state_d = fetch_entry_state(pc_d);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      valid_q      <= 1'b0;
      mis_q        <= 1'b0;
      inst_q       <= 32'h0;
      ipc_q        <= 32'h0;
      ipc4_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      mis_q        <= mis_d;
      inst_q       <= inst_d;
      ipc_q        <= ipc_d;
      ipc4_q       <= ipc4_d;
    end
  end

  assign imem_req      = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr     = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign if_valid      = valid_q;
  assign if_misaligned = mis_q;
  assign if_inst       = inst_q;
  assign if_pc         = ipc_q;
  assign if_pc4        = ipc4_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against an event-level model of the fetch rules.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_A = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall_in = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_misaligned;
  state_e      dbg_state;

  fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall_in      (stall_in),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .if_misaligned (if_misaligned),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Flags describe what the fetch unit is doing after the most recent edge.
  bit          m_known = 0;
  bit          m_start, m_wait, m_squash, m_show, m_fault;
  bit          m_valid, m_mis;
  logic [31:0] m_pc, m_drain_addr, m_inst, m_ipc, m_ipc4;

  function automatic void go(input logic [31:0] a);
    m_start = 0; m_wait = 0; m_squash = 0; m_show = 0; m_fault = 0;
    m_pc = a;
    if (a[1:0] != 2'b00) m_fault = 1;
    else m_wait = 1;
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      m_known = 1; m_start = 1; m_wait = 0; m_squash = 0; m_show = 0; m_fault = 0;
      m_pc = RST_PC; m_drain_addr = 32'h0;
      m_valid = 0; m_mis = 0; m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    end else if (m_known) begin
      if (redirect) begin
        m_valid = 0;
        m_mis = 0;
      end
      if (m_start) begin
        go(redirect ? redirect_pc : m_pc);
      end else if (m_wait) begin
        if (redirect && imem_ack) go(redirect_pc);
        else if (redirect) begin
          m_wait = 0; m_squash = 1; m_drain_addr = m_pc; m_pc = redirect_pc;
        end else if (imem_ack) begin
          m_valid = 1; m_inst = imem_rdata; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
          m_pc = m_pc + 32'd4; m_wait = 0; m_show = 1;
        end
      end else if (m_show) begin
        if (redirect) go(redirect_pc);
        else if (!stall_in) begin
          m_valid = 0;
          go(m_pc);
        end
      end else if (m_fault) begin
        if (redirect) go(redirect_pc);
        else begin
          m_valid = 1; m_mis = 1; m_inst = NOP; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        end
      end else if (m_squash) begin
        if (redirect) m_pc = redirect_pc;
        if (imem_ack) go(m_pc);
      end
    end
  endfunction

  // Compare process: outputs checked mid-cycle, then model advanced with the
  // inputs that the coming edge will sample.
  always @(negedge clk) begin
    if (m_known) begin
      check("imem_req", 32'(imem_req), 32'(m_wait || m_squash));
      if (m_wait || m_squash)
        check("imem_addr", imem_addr, m_wait ? m_pc : m_drain_addr);
      check("if_valid", 32'(if_valid), 32'(m_valid));
      check("if_misaligned", 32'(if_misaligned), 32'(m_mis));
      if (m_valid) begin
        check("if_inst", if_inst, m_inst);
        check("if_pc", if_pc, m_ipc);
        check("if_pc4", if_pc4, m_ipc4);
      end
    end
    model_step();
  end

  // ---------------- driver ----------------
  int          ack_lat = 1;
  int          req_age = 0;
  bit          rnd_mode = 0;

  // One cycle: inputs change 2 ns after the edge; redirect is a one-cycle pulse.
  task automatic step();
    @(posedge clk);
    #2;
    redirect = 1'b0;
    if (imem_req) begin
      if (req_age >= ack_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = rnd_mode ? $urandom : INST_A;
        req_age    = 0;
        if (rnd_mode) ack_lat = $urandom_range(0, 3);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        req_age++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      req_age    = 0;
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    do begin step(); n++; end while (!imem_req && n < 40);
    if (!imem_req) timeout_fail(name);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin step(); n++; end while (!if_valid && n < 40);
    if (!if_valid) timeout_fail(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen_valid;
    int   n;

    rst_n = 1'b0;
    repeat (3) step();
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_mis", 32'(if_misaligned), 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc4", if_pc4, 32'h0);

    // Basic fetch with 1-cycle ack.
    rst_n = 1'b1;
    wait_req("first_req");
    check("first_addr", imem_addr, 32'h0);
    wait_valid("first_valid");
    check("first_pc", if_pc, 32'h0);
    check("first_pc4", if_pc4, 32'h4);
    check("first_inst", if_inst, INST_A);
    wait_req("second_req");
    check("second_addr", imem_addr, 32'h4);

    // Stall holds the presented entry.
    wait_valid("stall_valid");
    stall_in = 1'b1;
    repeat (3) begin
      step();
      check("stall_valid", 32'(if_valid), 32'h1);
      check("stall_pc", if_pc, 32'h4);
      check("stall_req", 32'(imem_req), 32'h0);
    end
    stall_in = 1'b0;
    ack_lat = 3;
    wait_req("post_stall_req");
    check("post_stall_addr", imem_addr, 32'h8);

    // Redirect while the fetch at 0x8 is still outstanding.
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    check("drain_addr", imem_addr, 32'h8);
    seen_valid = 1'b0;
    n = 0;
    while (!(imem_req && imem_addr == 32'h100) && n < 20) begin
      step();
      seen_valid |= if_valid;
      n++;
    end
    if (n >= 20) timeout_fail("drain_exit");
    check("squash_no_valid", 32'(seen_valid), 32'h0);

    // Misaligned redirect target.
    ack_lat = 0;
    wait_valid("valid_100");
    check("valid_100_pc", if_pc, 32'h100);
    redirect = 1'b1;
    redirect_pc = 32'h102;
    step();
    step();
    repeat (3) begin
      check("exc_req", 32'(imem_req), 32'h0);
      check("exc_valid", 32'(if_valid), 32'h1);
      check("exc_mis", 32'(if_misaligned), 32'h1);
      check("exc_inst", if_inst, NOP);
      check("exc_pc", if_pc, 32'h102);
      check("exc_pc4", if_pc4, 32'h106);
      step();
    end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    wait_req("resume_req");
    check("resume_addr", imem_addr, 32'h200);
    check("resume_mis", 32'(if_misaligned), 32'h0);

    // Redirect coincident with the ack: data dropped, refetch at target.
    redirect = 1'b1;
    redirect_pc = 32'h300;
    step();
    check("coinc_req", 32'(imem_req), 32'h1);
    check("coinc_addr", imem_addr, 32'h300);
    check("coinc_valid", 32'(if_valid), 32'h0);
    wait_valid("valid_300");
    check("valid_300_pc", if_pc, 32'h300);

    // Wraparound of pc+4.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    wait_valid("valid_wrap");
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc4, 32'h0);
    ack_lat = 5;
    wait_req("wrap_req");
    check("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of a drain.
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    check("drain2_req", 32'(imem_req), 32'h1);
    rst_n = 1'b0;
    step();
    check("mid_rst_req", 32'(imem_req), 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_valid", 32'(if_valid), 32'h0);
    check("mid_rst_inst", if_inst, 32'h0);
    rst_n = 1'b1;
    ack_lat = 1;
    wait_req("after_rst_req");
    check("after_rst_addr", imem_addr, RST_PC);

    // Randomized traffic, checked by the compare process.
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      stall_in = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect = 1'b1;
        case ($urandom_range(0, 3))
          0: redirect_pc = {$urandom_range(0, 32'hFFFF), 2'b00} << 2;
          1: redirect_pc = {$urandom} | 32'h1;
          2: redirect_pc = 32'hFFFF_FFF8 | ($urandom_range(0, 1) << 2);
          default: redirect_pc = $urandom & 32'hFFFF_FFFC;
        endcase
      end
    end
    rst_n = 1'b1;
    stall_in = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
